// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, control-bit layout and the
// control bundle type used by the ID, EX, MEM and WB stages.
package mips_pkg;

    localparam int PC_W = 7;
    localparam int XLEN = 32;
    localparam int NREG = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam int C_REGWRITE = 7;
    localparam int C_MEMREAD  = 6;
    localparam int C_MEMWRITE = 5;
    localparam int C_MEMTOREG = 4;
    localparam int C_ALUSRC   = 3;
    localparam int C_REGDST   = 2;
    localparam int C_BRANCH   = 1;
    localparam int C_ALUOP_R  = 0;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic alusrc;
        logic regdst;
        logic branch;
        logic aluop_r;
    } ctrl_t;

    // Opcodes whose rt field is a source operand (not a destination).
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// Register file: NREG x XLEN, two async read ports, one write port,
// with write-before-read bypass from the writeback port.
module reg_file
    import mips_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [4:0]   i_ra,
    input  logic [4:0]   i_rb,
    input  logic         i_we,
    input  logic [4:0]   i_wa,
    input  logic [W-1:0] i_wd,
    output logic [W-1:0] o_rda,
    output logic [W-1:0] o_rdb
);

    logic [W-1:0] r_regs [N];
    logic         w_wr;

    assign w_wr = i_we && (i_wa != 5'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    always_comb begin
        o_rda = r_regs[i_ra];
        o_rdb = r_regs[i_rb];
        if (w_wr && i_wa == i_ra) o_rda = i_wd;
        if (w_wr && i_wa == i_rb) o_rdb = i_wd;
        if (i_ra == 5'd0) o_rda = '0;
        if (i_rb == 5'd0) o_rdb = '0;
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS ID stage: IF/ID latch, control decode, register read, immediate
// extension, ID/EX launch and load-use hazard stall.
module decode_stage
    import mips_pkg::*;
#(
    parameter int PC_W = 7,
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [XLEN-1:0] IFIDIR,
    input  logic [PC_W-1:0] IFPC,
    input  logic            IF_VALID,
    input  logic            FLUSH,
    input  logic            WB_EN,
    input  logic [4:0]      WB_ADDR,
    input  logic [XLEN-1:0] WB_DATA,
    output logic            STALL,
    output logic            IDEX_VALID,
    output logic [PC_W-1:0] IDEX_PC,
    output logic [XLEN-1:0] IDEX_A,
    output logic [XLEN-1:0] IDEX_B,
    output logic [XLEN-1:0] IDEX_IMM,
    output logic [4:0]      IDEX_RS,
    output logic [4:0]      IDEX_RT,
    output logic [4:0]      IDEX_RD,
    output logic [5:0]      IDEX_FUNCT,
    output logic [7:0]      IDEX_CTRL,
    output logic            ILLEGAL
);

    logic            r_ifid_valid;
    logic [PC_W-1:0] r_ifid_pc;
    logic [XLEN-1:0] r_ifid_ir;

    logic            r_idex_valid;
    logic [PC_W-1:0] r_idex_pc;
    logic [XLEN-1:0] r_idex_a;
    logic [XLEN-1:0] r_idex_b;
    logic [XLEN-1:0] r_idex_imm;
    logic [4:0]      r_idex_rs;
    logic [4:0]      r_idex_rt;
    logic [4:0]      r_idex_rd;
    logic [5:0]      r_idex_funct;
    ctrl_t           r_idex_ctrl;
    logic            r_illegal;

    logic [5:0]      w_op;
    logic [4:0]      w_rs;
    logic [4:0]      w_rt;
    logic [4:0]      w_rd;
    logic [5:0]      w_funct;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rda;
    logic [XLEN-1:0] w_rdb;
    ctrl_t           w_ctrl;
    logic            w_known;
    logic            w_stall;
    logic            w_launch;

    assign w_op    = r_ifid_ir[31:26];
    assign w_rs    = r_ifid_ir[25:21];
    assign w_rt    = r_ifid_ir[20:16];
    assign w_rd    = r_ifid_ir[15:11];
    assign w_funct = r_ifid_ir[5:0];
    assign w_imm   = {{(XLEN-16){r_ifid_ir[15]}}, r_ifid_ir[15:0]};

    reg_file #(
        .W (XLEN),
        .N (NREG)
    ) u_rf (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_ra    (w_rs),
        .i_rb    (w_rt),
        .i_we    (WB_EN),
        .i_wa    (WB_ADDR),
        .i_wd    (WB_DATA),
        .o_rda   (w_rda),
        .o_rdb   (w_rdb)
    );

    always_comb begin
        w_ctrl  = '0;
        w_known = 1'b1;
        unique case (1'b1)
            (w_op == OP_RTYPE): begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.regdst   = 1'b1;
                w_ctrl.aluop_r  = 1'b1;
            end
            (w_op == OP_LW): begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.memread  = 1'b1;
                w_ctrl.memtoreg = 1'b1;
                w_ctrl.alusrc   = 1'b1;
            end
            (w_op == OP_SW): begin
                w_ctrl.memwrite = 1'b1;
                w_ctrl.alusrc   = 1'b1;
            end
            (w_op == OP_BEQ): begin
                w_ctrl.branch = 1'b1;
            end
            (w_op == OP_ADDI): begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.alusrc   = 1'b1;
            end
            default: w_known = 1'b0;
        endcase
    end

    // A flush redirects fetch, so it must never be masked by a stall.
    assign w_stall = !FLUSH && r_idex_valid && r_idex_ctrl.memread
                     && (r_idex_rt != 5'd0) && r_ifid_valid
                     && ((r_idex_rt == w_rs)
                         || ((r_idex_rt == w_rt) && uses_rt(w_op)));

    assign w_launch = r_ifid_valid && !w_stall && !FLUSH;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_ir    <= '0;
        end else if (FLUSH) begin
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_ir    <= '0;
        end else if (!w_stall) begin
            r_ifid_valid <= IF_VALID;
            r_ifid_pc    <= IFPC;
            r_ifid_ir    <= IFIDIR;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_idex_valid <= 1'b0;
            r_idex_pc    <= '0;
            r_idex_a     <= '0;
            r_idex_b     <= '0;
            r_idex_imm   <= '0;
            r_idex_rs    <= '0;
            r_idex_rt    <= '0;
            r_idex_rd    <= '0;
            r_idex_funct <= '0;
            r_idex_ctrl  <= '0;
            r_illegal    <= 1'b0;
        end else if (!w_launch) begin
            r_idex_valid <= 1'b0;
            r_idex_pc    <= '0;
            r_idex_a     <= '0;
            r_idex_b     <= '0;
            r_idex_imm   <= '0;
            r_idex_rs    <= '0;
            r_idex_rt    <= '0;
            r_idex_rd    <= '0;
            r_idex_funct <= '0;
            r_idex_ctrl  <= '0;
            r_illegal    <= 1'b0;
        end else begin
            r_idex_valid <= 1'b1;
            r_idex_pc    <= r_ifid_pc;
            r_idex_a     <= w_rda;
            r_idex_b     <= w_rdb;
            r_idex_imm   <= w_imm;
            r_idex_rs    <= w_rs;
            r_idex_rt    <= w_rt;
            r_idex_rd    <= w_rd;
            r_idex_funct <= w_funct;
            r_idex_ctrl  <= w_ctrl;
            r_illegal    <= !w_known;
        end
    end

    assign STALL      = w_stall;
    assign IDEX_VALID = r_idex_valid;
    assign IDEX_PC    = r_idex_pc;
    assign IDEX_A     = r_idex_a;
    assign IDEX_B     = r_idex_b;
    assign IDEX_IMM   = r_idex_imm;
    assign IDEX_RS    = r_idex_rs;
    assign IDEX_RT    = r_idex_rt;
    assign IDEX_RD    = r_idex_rd;
    assign IDEX_FUNCT = r_idex_funct;
    assign IDEX_CTRL  = r_idex_ctrl;
    assign ILLEGAL    = r_illegal;

endmodule
